clkspec_mod16_16_seq: RTL and testbench

Sequential unsigned modulus responder that computes rm = dd mod dv. It is the external modulus block serving the data-driven GCD controller, which sends dd/dv and reads rm. The block accepts one operand pair, runs a restoring shift-subtract loop of one bit per clock, and holds the remainder until it is consumed. Only one operation is outstanding at a time.

---
 rtl/clkspec_mod16_16_seq_if.sv | 23 ++
 rtl/clkspec_mod16_16_seq.sv | 102 ++++++++++
 tb/tb_clkspec_mod16_16_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/clkspec_mod16_16_seq_if.sv
// Operand/remainder handshake bundle between the GCD controller (master) and the modulus block (slave).
// Operands use a valid/ready accept; the remainder is held under out_valid until out_ready.
interface clkspec_mod16_16_seq_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] dd;
  logic [WIDTH-1:0] dv;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rm;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output dd, dv, in_valid, out_ready,
    input  in_ready, rm, out_valid
  );

  modport slave (
    input  dd, dv, in_valid, out_ready,
    output in_ready, rm, out_valid
  );
endinterface

// File: rtl/clkspec_mod16_16_seq.sv
// Sequential rm = dd mod dv, restoring shift-subtract at one bit per clock: WIDTH cycles, or 1 when dv==0 or dd<dv.
// One operation in flight; operands only taken in IDLE, remainder held in DONE until out_ready.
module clkspec_mod16_16_seq #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  clkspec_mod16_16_seq_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rm_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step;

  // The restored remainder is always below dv, so it fits in WIDTH bits; only
  // the shifted trial value needs the extra bit. A borrow out of the trial
  // subtraction means shifted < dv and the old value is kept.
  always_comb begin
    shifted = {rem, dividend[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    step    = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      dividend    <= '0;
      divisor     <= '0;
      rem         <= '0;
      count       <= '0;
      rm_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dividend   <= bus.dd;
            divisor    <= bus.dv;
            in_ready_q <= 1'b0;
            if (bus.dv == '0 || bus.dd < bus.dv) begin
              rm_q        <= bus.dd;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              rem   <= '0;
              count <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          dividend <= {dividend[WIDTH-2:0], 1'b0};
          rem      <= step;
          if (count == LAST) begin
            count       <= '0;
            rm_q        <= step;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.rm        = rm_q;

endmodule

// File: tb/tb_clkspec_mod16_16_seq.sv
// Randomized and directed bench for clkspec_mod16_16_seq against a plain-arithmetic modulus model.
module tb_clkspec_mod16_16_seq;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  clkspec_mod16_16_seq_if #(.WIDTH(16)) bus ();

  clkspec_mod16_16_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mod(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'd0) return a;
    return a % b;
  endfunction

  // Issue one operation and follow it to release. Latency is counted in
  // clock edges after the accept edge; the fast path enters DONE on the
  // accept edge itself, so its result is already visible (0 extra edges).
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int stall, input bit poke, input bit rdy_early,
                        output logic [15:0] res);
    int lat;
    int waited;
    int exp_lat;
    logic [15:0] exp_rm;
    exp_rm  = ref_mod(a, b);
    exp_lat = (b == 16'd0 || a < b) ? 0 : 16;
    waited  = 0;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "/accept_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.dd        = a;
    bus.dv        = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = rdy_early;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dd       = 16'($urandom);
    bus.dv       = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      if (lat == 0) chk({tag, "/busy_rdy"}, 32'(bus.in_ready), 32'd0);
      bus.in_valid = poke;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/rm"}, 32'(bus.rm), 32'(exp_rm));
    res = bus.rm;
    for (int i = 0; i < stall; i++) begin
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "/hold_vld"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "/hold_rm"}, 32'(bus.rm), 32'(exp_rm));
      chk({tag, "/hold_rdy"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "/drop_vld"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "/next_rdy"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "/keep_rm"}, 32'(bus.rm), 32'(exp_rm));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    logic [15:0] a;
    logic [15:0] b;
    bit          seen;
    int          waited;

    reset         = 1'b0;
    bus.dd        = '0;
    bus.dv        = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("reset/in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset/out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset/rm", 32'(bus.rm), 32'd0);

    run_op("d100_7", 16'd100, 16'd7, 0, 1'b0, 1'b1, r);
    run_op("div0", 16'd5, 16'd0, 0, 1'b0, 1'b1, r);
    run_op("small", 16'd3, 16'd10, 0, 1'b0, 1'b1, r);
    run_op("ffff_8000", 16'hFFFF, 16'h8000, 0, 1'b0, 1'b0, r);
    run_op("ffff_1", 16'hFFFF, 16'h0001, 1, 1'b0, 1'b0, r);
    run_op("equal", 16'h1234, 16'h1234, 0, 1'b0, 1'b0, r);
    run_op("zero_dd", 16'd0, 16'd9, 0, 1'b0, 1'b0, r);
    run_op("bp48_18", 16'd48, 16'd18, 5, 1'b1, 1'b0, r);

    // Reset partway through an iteration: the result must be discarded.
    bus.dd = 16'd100; bus.dv = 16'd7; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rst_calc/in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_calc/out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_calc/rm", 32'(bus.rm), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("rst_calc/no_result", 32'(seen), 32'd0);
    run_op("after_rst", 16'd100, 16'd7, 0, 1'b0, 1'b1, r);

    // GCD chain fed back-to-back from each remainder.
    a = 16'd48; b = 16'd18;
    run_op("gcd1", a, b, 0, 1'b0, 1'b1, r);
    a = b; b = r;
    run_op("gcd2", a, b, 0, 1'b0, 1'b1, r);
    chk("gcd2/value", 32'(r), 32'd6);
    a = b; b = r;
    run_op("gcd3", a, b, 0, 1'b0, 1'b1, r);

    // Reset while a result is being held.
    bus.dd = 16'h1234; bus.dv = 16'h0100; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    waited = 0;
    while (!bus.out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_done/pre_rm", 32'(bus.rm), 32'h34);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rst_done/out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_done/rm", 32'(bus.rm), 32'd0);
    chk("rst_done/in_ready", 32'(bus.in_ready), 32'd1);

    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 4))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = a;
        3:       b = 16'($urandom);
        default: b = a >> $urandom_range(1, 8);
      endcase
      run_op($sformatf("rnd%0d", n), a, b, $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
